// File: rtl/dds_sample_gen.sv
// DDS sine sample source for the PWM dac: a phase accumulator feeds a quarter-wave ROM.
// A new offset-binary sample is produced on every next_sample strobe.
module dds_sample_gen #(
  parameter int unsigned PHASE_WIDTH    = 24,
  parameter int unsigned LUT_ADDR_WIDTH = 8,
  parameter int unsigned CODE_WIDTH     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   next_sample,
  input  logic                   en,
  input  logic [PHASE_WIDTH-1:0] fcw,
  input  logic                   fcw_valid,
  output logic [CODE_WIDTH-1:0]  code,
  output logic                   phase_wrap
);

  localparam int unsigned QAddrW      = LUT_ADDR_WIDTH - 2;
  localparam int unsigned QuarterSize = 2 ** QAddrW;
  localparam real         Pi          = 3.14159265358979323846;
  localparam real         Amplitude   = (2.0 ** (CODE_WIDTH - 1)) - 1.0;

  localparam logic [CODE_WIDTH-1:0] Midscale = {1'b1, {(CODE_WIDTH - 1){1'b0}}};
  localparam logic [CODE_WIDTH-1:0] MidLow   = {1'b0, {(CODE_WIDTH - 1){1'b1}}};

  // Quarter-wave table, sampled at bin centres so the mirrored quadrants are exact.
  logic [CODE_WIDTH-2:0] rom [QuarterSize];

  for (genvar k = 0; k < QuarterSize; k++) begin : g_rom
    localparam real Angle = 2.0 * Pi * (real'(k) + 0.5) / (2.0 ** LUT_ADDR_WIDTH);
    localparam int  Val   = $rtoi(Amplitude * $sin(Angle) + 0.5);
    assign rom[k] = (CODE_WIDTH - 1)'(Val);
  end

  logic [PHASE_WIDTH-1:0]    phase_q, phase_d;
  logic [PHASE_WIDTH-1:0]    fcw_active_q, fcw_active_d;
  logic [PHASE_WIDTH-1:0]    fcw_pending_q, fcw_pending_d;
  logic                      pending_q, pending_d;
  logic [CODE_WIDTH-1:0]     code_q, code_d;
  logic                      wrap_q, wrap_d;

  logic [LUT_ADDR_WIDTH-1:0] lut_idx;
  logic [1:0]                quad;
  logic [QAddrW-1:0]         qaddr;
  logic [QAddrW-1:0]         qaddr_m;
  logic [CODE_WIDTH-2:0]     rom_val;
  logic [CODE_WIDTH-1:0]     lut_code;
  logic [PHASE_WIDTH:0]      phase_sum;

  always_comb begin
    lut_idx  = phase_q[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
    quad     = lut_idx[LUT_ADDR_WIDTH-1 -: 2];
    qaddr    = lut_idx[QAddrW-1:0];
    qaddr_m  = quad[0] ? ~qaddr : qaddr;
    rom_val  = rom[qaddr_m];
    lut_code = quad[1] ? (MidLow - CODE_WIDTH'(rom_val)) : (Midscale + CODE_WIDTH'(rom_val));
    phase_sum = {1'b0, phase_q} + {1'b0, fcw_active_q};
  end

  // Tuning word double-buffer: the accumulator on a boundary edge still sees the old word.
  always_comb begin
    fcw_pending_d = fcw_pending_q;
    pending_d     = pending_q;
    fcw_active_d  = fcw_active_q;
    if (fcw_valid) begin
      fcw_pending_d = fcw;
      pending_d     = 1'b1;
    end
    if (next_sample && (pending_q || fcw_valid)) begin
      fcw_active_d = fcw_valid ? fcw : fcw_pending_q;
      pending_d    = 1'b0;
    end
  end

  always_comb begin
    code_d  = code_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (next_sample) begin
      if (en) begin
        code_d  = lut_code;
        phase_d = phase_sum[PHASE_WIDTH-1:0];
        wrap_d  = phase_sum[PHASE_WIDTH];
      end else begin
        code_d = Midscale;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= '0;
      fcw_active_q  <= '0;
      fcw_pending_q <= '0;
      pending_q     <= 1'b0;
      code_q        <= Midscale;
      wrap_q        <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      fcw_active_q  <= fcw_active_d;
      fcw_pending_q <= fcw_pending_d;
      pending_q     <= pending_d;
      code_q        <= code_d;
      wrap_q        <= wrap_d;
    end
  end

  assign code       = code_q;
  assign phase_wrap = wrap_q;

endmodule

// File: tb/tb_dds_sample_gen.sv
// Scoreboard bench for dds_sample_gen with PHASE_WIDTH=8, LUT_ADDR_WIDTH=4, CODE_WIDTH=3.
// Stimulus queues expected (code, wrap) per strobe; the monitor checks every cycle.
module tb_dds_sample_gen;

  logic       clk;
  logic       rst_n;
  logic       next_sample;
  logic       en;
  logic [7:0] fcw;
  logic       fcw_valid;
  logic [2:0] code;
  logic       phase_wrap;

  typedef struct packed {
    logic [2:0] code;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;
  logic bd;
  logic [2:0] hold_code;

  dds_sample_gen #(
    .PHASE_WIDTH   (8),
    .LUT_ADDR_WIDTH(4),
    .CODE_WIDTH    (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_sample(next_sample),
    .en         (en),
    .fcw        (fcw),
    .fcw_valid  (fcw_valid),
    .code       (code),
    .phase_wrap (phase_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: boundary cycles pop the scoreboard, other cycles must hold.
  initial begin
    forever begin
      @(posedge clk);
      bd = next_sample && rst_n;
      @(negedge clk);
      if (!rst_n) begin
        hold_code = 3'd4;
        q.delete();
        chk("reset_code", int'(code), 4);
        chk("reset_wrap", int'(phase_wrap), 0);
      end else if (bd) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_boundary: got code %0d expected no strobe", code);
        end else begin
          exp_t e;
          e = q.pop_front();
          hold_code = e.code;
          chk("boundary_code", int'(code), int'(e.code));
          chk("boundary_wrap", int'(phase_wrap), int'(e.wrap));
        end
      end else begin
        chk("hold_code", int'(code), int'(hold_code));
        chk("idle_wrap", int'(phase_wrap), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      next_sample = 1'b0;
      fcw_valid   = 1'b0;
    end
  endtask

  task automatic load(input logic [7:0] f);
    @(negedge clk);
    next_sample = 1'b0;
    fcw_valid   = 1'b1;
    fcw         = f;
  endtask

  task automatic strobe(input logic [2:0] c, input logic w, input logic ld, input logic [7:0] f);
    exp_t e;
    @(negedge clk);
    next_sample = 1'b1;
    fcw_valid   = ld;
    if (ld) fcw = f;
    e.code = c;
    e.wrap = w;
    q.push_back(e);
  endtask

  task automatic window(input logic [2:0] c, input logic w);
    idle(7);
    strobe(c, w, 1'b0, 8'd0);
  endtask

  logic [2:0] sweep [16] = '{3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd6, 3'd6, 3'd5,
                             3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
  logic [2:0] fast [4] = '{3'd5, 3'd7, 3'd2, 3'd0};

  initial begin
    checks      = 0;
    errors      = 0;
    hold_code   = 3'd4;
    rst_n       = 1'b0;
    next_sample = 1'b0;
    en          = 1'b1;
    fcw         = 8'd0;
    fcw_valid   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // No tuning word: phase stays at 0, lut(0) = 5.
    window(3'd5, 1'b0);
    window(3'd5, 1'b0);

    // Full sweep with fcw=16; the load boundary itself still uses fcw 0.
    idle(3);
    load(8'd16);
    idle(3);
    strobe(3'd5, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 16; i++) window(sweep[i], (i == 15));
    for (int i = 0; i < 4; i++) window(sweep[i], 1'b0);

    // Mute at phase 64, then resume at the held phase.
    idle(1);
    en = 1'b0;
    idle(6);
    strobe(3'd4, 1'b0, 1'b0, 8'd0);
    window(3'd4, 1'b0);
    idle(1);
    en = 1'b1;
    idle(6);
    strobe(3'd7, 1'b0, 1'b0, 8'd0);
    window(3'd6, 1'b0);

    // Load 64 together with the strobe: +16 this boundary, +64 afterwards.
    idle(7);
    strobe(3'd6, 1'b0, 1'b1, 8'd64);
    window(3'd5, 1'b0);
    window(3'd0, 1'b0);
    window(3'd2, 1'b1);
    window(3'd7, 1'b0);

    // Async reset mid-window with a pending word that must be discarded.
    idle(2);
    load(8'd32);
    idle(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_code", int'(code), 4);
    chk("async_rst_wrap", int'(phase_wrap), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    window(3'd5, 1'b0);
    window(3'd5, 1'b0);
    window(3'd5, 1'b0);

    // Fast tone: fcw=64 gives 5,7,2,0 with a wrap every fourth boundary.
    idle(3);
    load(8'd64);
    idle(3);
    strobe(3'd5, 1'b0, 1'b0, 8'd0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) window(fast[i], (i == 3));
    end

    idle(4);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
